// File: rtl/painter_pkg.sv
// Shared constants and enumerations for the VRAM write scheduler and its fill scanner.
package painter_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 2 * COORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    GNT_PIX  = 1'b0,
    GNT_FILL = 1'b1
  } grant_e;

endpackage

// File: rtl/vram_write_sched_if.sv
// Bundle of cursor request, fill command and VRAM write signals around vram_write_sched.
interface vram_write_sched_if #(
  parameter int COORD_W = painter_pkg::COORD_W,
  parameter int COLOR_W = painter_pkg::COLOR_W
);

  logic                   pix_req;
  logic [COORD_W-1:0]     pix_x;
  logic [COORD_W-1:0]     pix_y;
  logic [COLOR_W-1:0]     pix_color;
  logic                   pix_ack;

  logic                   fill_start;
  logic [COORD_W-1:0]     fill_x0;
  logic [COORD_W-1:0]     fill_y0;
  logic [COORD_W-1:0]     fill_x1;
  logic [COORD_W-1:0]     fill_y1;
  logic [COLOR_W-1:0]     fill_color;
  logic                   fill_busy;
  logic                   fill_done;

  logic                   vram_we;
  logic [2*COORD_W-1:0]   vram_wa;
  logic [COLOR_W-1:0]     vram_wd;

  modport master (
    output pix_req, pix_x, pix_y, pix_color,
    output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  pix_ack, fill_busy, fill_done,
    input  vram_we, vram_wa, vram_wd
  );

  modport slave (
    input  pix_req, pix_x, pix_y, pix_color,
    input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output pix_ack, fill_busy, fill_done,
    output vram_we, vram_wa, vram_wd
  );

endinterface

// File: rtl/fill_scanner.sv
// Rectangle walker: normalises corners on load and steps an {x,y} cursor row-major, x inner.
// With CLEAR_ON_RESET_EN the reset rectangle is the whole canvas.
module fill_scanner #(
  parameter int COORD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [COORD_W-1:0]   x0,
  input  logic [COORD_W-1:0]   y0,
  input  logic [COORD_W-1:0]   x1,
  input  logic [COORD_W-1:0]   y1,
  input  logic                 advance,
  output logic [2*COORD_W-1:0] addr,
  output logic                 last
);

  localparam logic [COORD_W-1:0] ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] MAXC = {COORD_W{1'b1}};

  logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r, fx_r, fy_r;
  logic [COORD_W-1:0] xmin_s, xmax_s, ymin_s, ymax_s, fx_s, fy_s;

  function automatic logic [COORD_W-1:0] min_of(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] max_of(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Next bounds/cursor: load takes priority over advance.
  always_comb begin
    xmin_s = xmin_r;
    xmax_s = xmax_r;
    ymin_s = ymin_r;
    ymax_s = ymax_r;
    fx_s   = fx_r;
    fy_s   = fy_r;
    if (load) begin
      xmin_s = min_of(x0, x1);
      xmax_s = max_of(x0, x1);
      ymin_s = min_of(y0, y1);
      ymax_s = max_of(y0, y1);
      fx_s   = min_of(x0, x1);
      fy_s   = min_of(y0, y1);
    end else if (advance) begin
      if (fx_r == xmax_r) begin
        fx_s = xmin_r;
        fy_s = fy_r + ONE;
      end else begin
        fx_s = fx_r + ONE;
      end
    end else begin
      fx_s = fx_r;
    end
  end

  // Bound and cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmin_r <= ZERO;
      ymin_r <= ZERO;
      fx_r   <= ZERO;
      fy_r   <= ZERO;
`ifdef CLEAR_ON_RESET_EN
      xmax_r <= MAXC;
      ymax_r <= MAXC;
`else
      xmax_r <= ZERO;
      ymax_r <= ZERO;
`endif
    end else begin
      xmin_r <= xmin_s;
      xmax_r <= xmax_s;
      ymin_r <= ymin_s;
      ymax_r <= ymax_s;
      fx_r   <= fx_s;
      fy_r   <= fy_s;
    end
  end

  // Equality compares keep the full 0..max canvas free of overflow issues.
  assign addr = {fx_r, fy_r};
  assign last = (fx_r == xmax_r) && (fy_r == ymax_r);

endmodule

// File: rtl/vram_write_sched.sv
// Round-robin owner of the VRAM write port shared by cursor pixel writes and a rectangle fill.
// CLEAR_ON_RESET_EN: when defined, a full-canvas fill with color 0 starts after reset.
module vram_write_sched #(
  parameter int COORD_W = painter_pkg::COORD_W,
  parameter int COLOR_W = painter_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  vram_write_sched_if.slave  bus
);

  import painter_pkg::*;

  localparam int WA_W = 2 * COORD_W;

  fill_state_e          state_r, state_s;
  grant_e               last_grant_r, last_grant_s;
  logic [COLOR_W-1:0]   color_r, color_s;

  logic                 pix_elig_s, fill_elig_s;
  logic                 gnt_pix_s, gnt_fill_s;
  logic                 scan_load_s;
  logic [WA_W-1:0]      fill_addr_s;
  logic                 fill_last_s;

  logic                 we_s;
  logic [WA_W-1:0]      wa_s;
  logic [COLOR_W-1:0]   wd_s;

  logic                 vram_we_r, pix_ack_r, fill_busy_r, fill_done_r;
  logic [WA_W-1:0]      vram_wa_r;
  logic [COLOR_W-1:0]   vram_wd_r;

  fill_scanner #(.COORD_W(COORD_W)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load_s),
    .x0      (bus.fill_x0),
    .y0      (bus.fill_y0),
    .x1      (bus.fill_x1),
    .y1      (bus.fill_y1),
    .advance (gnt_fill_s),
    .addr    (fill_addr_s),
    .last    (fill_last_s)
  );

  // Round-robin arbiter; a pixel request is masked while its ack is out so a dropping req is not rewritten.
  always_comb begin
    pix_elig_s   = bus.pix_req && !pix_ack_r;
    fill_elig_s  = (state_r == FILL);
    gnt_pix_s    = 1'b0;
    gnt_fill_s   = 1'b0;
    last_grant_s = last_grant_r;
    if (pix_elig_s && fill_elig_s) begin
      if (last_grant_r == GNT_FILL) begin
        gnt_pix_s = 1'b1;
      end else begin
        gnt_fill_s = 1'b1;
      end
    end else if (pix_elig_s) begin
      gnt_pix_s = 1'b1;
    end else if (fill_elig_s) begin
      gnt_fill_s = 1'b1;
    end else begin
      gnt_pix_s = 1'b0;
    end
    if (gnt_pix_s) begin
      last_grant_s = GNT_PIX;
    end else if (gnt_fill_s) begin
      last_grant_s = GNT_FILL;
    end else begin
      last_grant_s = last_grant_r;
    end
  end

  // Fill FSM next state; fill_start only matters in IDLE.
  always_comb begin
    state_s     = state_r;
    scan_load_s = 1'b0;
    color_s     = color_r;
    case (state_r)
      IDLE: begin
        if (bus.fill_start) begin
          scan_load_s = 1'b1;
          color_s     = bus.fill_color;
          state_s     = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (gnt_fill_s && fill_last_s) begin
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Write mux; address/data hold their last value when no write is granted.
  always_comb begin
    we_s = gnt_pix_s || gnt_fill_s;
    wa_s = vram_wa_r;
    wd_s = vram_wd_r;
    if (gnt_pix_s) begin
      wa_s = {bus.pix_x, bus.pix_y};
      wd_s = bus.pix_color;
    end else if (gnt_fill_s) begin
      wa_s = fill_addr_s;
      wd_s = color_r;
    end else begin
      wa_s = vram_wa_r;
    end
  end

  // FSM, arbitration history and latched fill color.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef CLEAR_ON_RESET_EN
      state_r <= FILL;
`else
      state_r <= IDLE;
`endif
      last_grant_r <= GNT_FILL;
      color_r      <= {COLOR_W{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      color_r      <= color_s;
    end
  end

  // Registered outputs, one cycle after the grant decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_we_r   <= 1'b0;
      vram_wa_r   <= {WA_W{1'b0}};
      vram_wd_r   <= {COLOR_W{1'b0}};
      pix_ack_r   <= 1'b0;
      fill_busy_r <= 1'b0;
      fill_done_r <= 1'b0;
    end else begin
      vram_we_r   <= we_s;
      vram_wa_r   <= wa_s;
      vram_wd_r   <= wd_s;
      pix_ack_r   <= gnt_pix_s;
      fill_busy_r <= (state_s != IDLE);
      fill_done_r <= gnt_fill_s && fill_last_s;
    end
  end

  assign bus.vram_we   = vram_we_r;
  assign bus.vram_wa   = vram_wa_r;
  assign bus.vram_wd   = vram_wd_r;
  assign bus.pix_ack   = pix_ack_r;
  assign bus.fill_busy = fill_busy_r;
  assign bus.fill_done = fill_done_r;

endmodule

// File: tb/tb_vram_write_sched.sv
// Directed self-checking bench for vram_write_sched (default build, CLEAR_ON_RESET_EN undefined).
`timescale 1ns/1ps
module tb_vram_write_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  vram_write_sched_if bus ();

  vram_write_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1,
                            input logic [11:0] c);
    bus.fill_x0    = x0;
    bus.fill_y0    = y0;
    bus.fill_x1    = x1;
    bus.fill_y1    = y1;
    bus.fill_color = c;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
  endtask

  initial begin
    logic [15:0] e4 [4];
    logic [15:0] e3 [3];
    logic [15:0] last_a;
    logic [15:0] exp_a;
    int          wr;
    int          order_err;
    bit          seen_done;

    rst            = 1'b1;
    bus.pix_req    = 1'b0;
    bus.pix_x      = 8'd0;
    bus.pix_y      = 8'd0;
    bus.pix_color  = 12'h000;
    bus.fill_start = 1'b0;
    bus.fill_x0    = 8'd0;
    bus.fill_y0    = 8'd0;
    bus.fill_x1    = 8'd0;
    bus.fill_y1    = 8'd0;
    bus.fill_color = 12'h000;
    tick();
    tick();

    check("rst_we",   32'(bus.vram_we),   32'd0);
    check("rst_wa",   32'(bus.vram_wa),   32'd0);
    check("rst_wd",   32'(bus.vram_wd),   32'd0);
    check("rst_ack",  32'(bus.pix_ack),   32'd0);
    check("rst_busy", 32'(bus.fill_busy), 32'd0);
    check("rst_done", 32'(bus.fill_done), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_we", 32'(bus.vram_we), 32'd0);

    // Single pixel write, req held one extra cycle.
    bus.pix_x     = 8'd5;
    bus.pix_y     = 8'd7;
    bus.pix_color = 12'hF00;
    bus.pix_req   = 1'b1;
    tick();
    check("pix_we",  32'(bus.vram_we), 32'd1);
    check("pix_wa",  32'(bus.vram_wa), 32'h0507);
    check("pix_wd",  32'(bus.vram_wd), 32'hF00);
    check("pix_ack", 32'(bus.pix_ack), 32'd1);
    tick();
    check("pix_nodup_we",  32'(bus.vram_we), 32'd0);
    check("pix_nodup_ack", 32'(bus.pix_ack), 32'd0);
    bus.pix_req = 1'b0;
    tick();
    check("pix_after_we", 32'(bus.vram_we), 32'd0);

    // Swapped-corner fill.
    e4[0] = 16'h0A14; e4[1] = 16'h0B14; e4[2] = 16'h0A15; e4[3] = 16'h0B15;
    start_fill(8'd11, 8'd21, 8'd10, 8'd20, 12'h0F0);
    check("swap_busy0", 32'(bus.fill_busy), 32'd1);
    check("swap_we0",   32'(bus.vram_we),   32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("swap_we",   32'(bus.vram_we),   32'd1);
      check("swap_wa",   32'(bus.vram_wa),   32'(e4[i]));
      check("swap_wd",   32'(bus.vram_wd),   32'h0F0);
      check("swap_done", 32'(bus.fill_done), (i == 3) ? 32'd1 : 32'd0);
      check("swap_busy", 32'(bus.fill_busy), 32'd1);
    end
    tick();
    check("swap_end_busy", 32'(bus.fill_busy), 32'd0);
    check("swap_end_done", 32'(bus.fill_done), 32'd0);
    check("swap_end_we",   32'(bus.vram_we),   32'd0);

    // Contention: fill 0..3 x 0 against a held pixel request; last grant was FILL so pixel goes first.
    start_fill(8'd0, 8'd0, 8'd3, 8'd0, 12'h00F);
    bus.pix_x     = 8'd100;
    bus.pix_y     = 8'd100;
    bus.pix_color = 12'hABC;
    bus.pix_req   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("cont_we",   32'(bus.vram_we), 32'd1);
      if (i % 2 == 0) begin
        check("cont_pix_wa", 32'(bus.vram_wa), 32'h6464);
        check("cont_pix_wd", 32'(bus.vram_wd), 32'hABC);
        check("cont_ack",    32'(bus.pix_ack), 32'd1);
      end else begin
        check("cont_fill_wa", 32'(bus.vram_wa), 32'((i / 2) << 8));
        check("cont_fill_wd", 32'(bus.vram_wd), 32'h00F);
        check("cont_noack",   32'(bus.pix_ack), 32'd0);
      end
      check("cont_done", 32'(bus.fill_done), (i == 7) ? 32'd1 : 32'd0);
    end
    bus.pix_req = 1'b0;
    tick();
    check("cont_end_we",   32'(bus.vram_we),   32'd0);
    check("cont_end_busy", 32'(bus.fill_busy), 32'd0);

    // Degenerate one-pixel rectangle.
    start_fill(8'd9, 8'd9, 8'd9, 8'd9, 12'h123);
    tick();
    check("deg_we",   32'(bus.vram_we),   32'd1);
    check("deg_wa",   32'(bus.vram_wa),   32'h0909);
    check("deg_done", 32'(bus.fill_done), 32'd1);
    tick();
    check("deg_end_we",   32'(bus.vram_we),   32'd0);
    check("deg_end_busy", 32'(bus.fill_busy), 32'd0);

    // fill_start mid-fill is ignored.
    e3[0] = 16'h0203; e3[1] = 16'h0303; e3[2] = 16'h0403;
    start_fill(8'd2, 8'd3, 8'd4, 8'd3, 12'h555);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        bus.fill_x0    = 8'd50;
        bus.fill_y0    = 8'd50;
        bus.fill_x1    = 8'd60;
        bus.fill_y1    = 8'd60;
        bus.fill_color = 12'hFFF;
        bus.fill_start = 1'b1;
      end else begin
        bus.fill_start = 1'b0;
      end
      check("mid_we",   32'(bus.vram_we),   32'd1);
      check("mid_wa",   32'(bus.vram_wa),   32'(e3[i]));
      check("mid_wd",   32'(bus.vram_wd),   32'h555);
      check("mid_done", 32'(bus.fill_done), (i == 2) ? 32'd1 : 32'd0);
    end
    wr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.vram_we) wr++;
    end
    check("mid_extra_writes", 32'(wr),            32'd0);
    check("mid_end_busy",     32'(bus.fill_busy), 32'd0);

    // Full canvas.
    start_fill(8'd0, 8'd0, 8'd255, 8'd255, 12'h777);
    wr        = 0;
    order_err = 0;
    seen_done = 1'b0;
    last_a    = 16'h0000;
    for (int c = 0; c < 70000 && !seen_done; c++) begin
      tick();
      if (bus.vram_we) begin
        exp_a = {wr[7:0], wr[15:8]};
        if (bus.vram_wa !== exp_a || bus.vram_wd !== 12'h777) order_err++;
        last_a = bus.vram_wa;
        wr++;
      end
      if (bus.fill_done) seen_done = 1'b1;
    end
    check("full_done_seen", 32'(seen_done), 32'd1);
    check("full_count",     32'(wr),        32'd65536);
    check("full_last",      32'(last_a),    32'hFFFF);
    check("full_order",     32'(order_err), 32'd0);
    tick();
    check("full_nowrap_we", 32'(bus.vram_we),   32'd0);
    check("full_end_busy",  32'(bus.fill_busy), 32'd0);

    // Asynchronous reset during a fill.
    start_fill(8'd0, 8'd0, 8'd15, 8'd15, 12'hAAA);
    tick();
    tick();
    check("arst_pre_we", 32'(bus.vram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",   32'(bus.vram_we),   32'd0);
    check("arst_busy", 32'(bus.fill_busy), 32'd0);
    tick();
    rst = 1'b0;
    wr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.vram_we) wr++;
    end
    check("arst_no_writes", 32'(wr),            32'd0);
    check("arst_idle_busy", 32'(bus.fill_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
